// File: rtl/uart_tx_mmio_if.sv
// rtl/uart_tx_mmio_if.sv - core data-bus view of the memory-mapped UART transmitter
interface uart_tx_mmio_if;
    logic        MemWrite;
    logic [31:0] DataAdr;
    logic [31:0] WriteData;
    logic        hit;
    logic [31:0] rdata;

    modport master (
        output MemWrite, DataAdr, WriteData,
        input  hit, rdata
    );

    modport slave (
        input  MemWrite, DataAdr, WriteData,
        output hit, rdata
    );
endinterface

// File: rtl/uart_tx_mmio.sv
// rtl/uart_tx_mmio.sv - memory-mapped 8N1 UART transmitter with TX FIFO and status register
module uart_tx_mmio #(
    parameter logic [31:0] BASE_ADDR    = 32'h0000_1000,
    parameter int          CLKS_PER_BIT = 16,
    parameter int          FIFO_DEPTH   = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    uart_tx_mmio_if.slave bus,
    output logic          tx
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int BW = $clog2(CLKS_PER_BIT);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state;
    logic [BW-1:0] baud;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          ovf;

    logic          hit_w;
    logic          wr_txdata;
    logic          wr_status;
    logic          full;
    logic          push;
    logic          pop;
    logic          baud_last;
    logic          busy;
    logic [31:0]   status;
    logic          unused_bits;

    assign hit_w     = (bus.DataAdr[31:3] == BASE_ADDR[31:3]);
    assign wr_txdata = bus.MemWrite & hit_w & ~bus.DataAdr[2];
    assign wr_status = bus.MemWrite & hit_w & bus.DataAdr[2];
    assign full      = (count == CW'(FIFO_DEPTH));
    // Acceptance uses the pre-edge count, so a simultaneous pop never frees a slot early.
    assign push      = wr_txdata & ~full;
    assign baud_last = (baud == BW'(CLKS_PER_BIT - 1));
    assign pop       = (count != '0) & ((state == IDLE) | ((state == STOP) & baud_last));
    assign busy      = (state != IDLE) | (count != '0);
    assign status    = {24'h0, 4'(count), 1'b0, ovf, full, busy};

    assign bus.hit   = hit_w;
    assign bus.rdata = (hit_w & bus.DataAdr[2]) ? status : 32'h0;

    assign unused_bits = ^{bus.WriteData[31:8], bus.DataAdr[1:0]};

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= bus.WriteData[7:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CW'(push) - CW'(pop);
            if (wr_txdata & full) begin
                ovf <= 1'b1;
            end else if (wr_status & bus.WriteData[2]) begin
                ovf <= 1'b0;
            end
        end
    end

    // tx is loaded with the next bit on each transition so it stays a clean register output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            tx      <= 1'b1;
            baud    <= '0;
            bit_idx <= '0;
            shift   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    tx   <= 1'b1;
                    baud <= '0;
                    if (pop) begin
                        shift <= mem[rd_ptr];
                        state <= START;
                        tx    <= 1'b0;
                    end
                end
                START: begin
                    if (baud_last) begin
                        baud    <= '0;
                        bit_idx <= '0;
                        state   <= DATA;
                        tx      <= shift[0];
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
                DATA: begin
                    if (baud_last) begin
                        baud <= '0;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                            tx    <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                            shift   <= shift >> 1;
                            tx      <= shift[1];
                        end
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
                STOP: begin
                    if (baud_last) begin
                        baud <= '0;
                        if (pop) begin
                            shift <= mem[rd_ptr];
                            state <= START;
                            tx    <= 1'b0;
                        end else begin
                            state <= IDLE;
                            tx    <= 1'b1;
                        end
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    tx    <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_mmio.sv
// tb/tb_uart_tx_mmio.sv - self-checking bench for uart_tx_mmio against a frame-timing reference model
module tb_uart_tx_mmio;
    localparam int C  = 4;
    localparam int D  = 4;
    localparam int FB = 10 * C;

    logic clk = 1'b0;
    logic rst_n;
    logic tx;

    uart_tx_mmio_if bus ();

    uart_tx_mmio #(
        .BASE_ADDR   (32'h0000_1000),
        .CLKS_PER_BIT(C),
        .FIFO_DEPTH  (D)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus),
        .tx   (tx)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    int         cyc    = 0;
    int         fstart = 0;
    logic       ovf_m  = 1'b0;
    logic [7:0] exp_q[$];
    logic [7:0] pend[$];

    // Accepted bytes go out as contiguous frames starting at edge fstart.
    function automatic logic model_tx();
        for (int j = 0; j < exp_q.size(); j++) begin
            int s = fstart + FB * j;
            if (cyc >= s && cyc < s + FB) begin
                int k = (cyc - s) / C;
                if (k == 0) return 1'b0;
                if (k <= 8) return exp_q[j][k-1];
                return 1'b1;
            end
        end
        return 1'b1;
    endfunction

    function automatic int pops_through(int e);
        int n = 0;
        for (int j = 0; j < exp_q.size(); j++) begin
            if (fstart + FB * j <= e) n++;
        end
        return n;
    endfunction

    function automatic int count_m();
        if (exp_q.size() == 0) return 0;
        return exp_q.size() - pops_through(cyc);
    endfunction

    function automatic logic busy_m();
        return (exp_q.size() != 0) && (cyc < fstart + FB * exp_q.size());
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        @(negedge clk);
        chk("tx", {31'b0, tx}, {31'b0, model_tx()});
    endtask

    task automatic check_status();
        logic [31:0] e;
        int          cnt;
        bus.MemWrite = 1'b0;
        bus.DataAdr  = 32'h0000_1004;
        #1;
        cnt  = count_m();
        e    = 32'h0;
        e[7:4] = 4'(cnt);
        e[2] = ovf_m;
        e[1] = (cnt == D);
        e[0] = busy_m();
        chk("status", bus.rdata, e);
        chk("hit_status", {31'b0, bus.hit}, 32'h1);
    endtask

    task automatic burst();
        logic [31:0] wd;
        int          e;
        int          cnt;
        foreach (pend[i]) begin
            wd           = $urandom();
            wd[7:0]      = pend[i];
            bus.MemWrite = 1'b1;
            bus.DataAdr  = 32'h0000_1000 | 32'($urandom_range(0, 3));
            bus.WriteData = wd;
            e = cyc + 1;
            if (exp_q.size() == 0) begin
                exp_q.push_back(pend[i]);
                fstart = e + 1;
            end else begin
                cnt = exp_q.size() - pops_through(e - 1);
                if (cnt < D) exp_q.push_back(pend[i]);
                else ovf_m = 1'b1;
            end
            step();
        end
        bus.MemWrite = 1'b0;
        pend.delete();
    endtask

    task automatic run_idle();
        while (exp_q.size() != 0 && cyc < fstart + FB * exp_q.size() + 2) begin
            step();
            check_status();
        end
        exp_q.delete();
    endtask

    task automatic reg_write(input logic [31:0] addr, input logic [31:0] data);
        bus.MemWrite  = 1'b1;
        bus.DataAdr   = addr;
        bus.WriteData = data;
        step();
        bus.MemWrite = 1'b0;
        if (addr[2] && data[2]) ovf_m = 1'b0;
        check_status();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n         = 1'b0;
        bus.MemWrite  = 1'b0;
        bus.DataAdr   = 32'h0;
        bus.WriteData = 32'h0;
        repeat (3) step();
        rst_n = 1'b1;

        bus.DataAdr = 32'h0;
        #1;
        chk("hit_zero_addr", {31'b0, bus.hit}, 32'h0);
        chk("rdata_miss", bus.rdata, 32'h0);
        repeat (100) begin
            step();
            check_status();
        end

        pend.push_back(8'hA5);
        burst();
        run_idle();

        pend.push_back(8'h55);
        pend.push_back(8'hC3);
        burst();
        run_idle();

        repeat (6) pend.push_back(8'($urandom()));
        burst();
        check_status();
        bus.DataAdr = 32'h0000_1000;
        #1;
        chk("txdata_read", bus.rdata, 32'h0);
        chk("hit_txdata", {31'b0, bus.hit}, 32'h1);
        run_idle();
        reg_write(32'h0000_1004, 32'hFFFF_FFFB);
        reg_write(32'h0000_1004, 32'h0000_0004);

        bus.MemWrite  = 1'b1;
        bus.DataAdr   = 32'h0000_2000;
        bus.WriteData = $urandom();
        #1;
        chk("hit_other", {31'b0, bus.hit}, 32'h0);
        chk("rdata_other", bus.rdata, 32'h0);
        step();
        bus.MemWrite = 1'b0;
        check_status();
        repeat (20) step();

        pend.push_back(8'h00);
        pend.push_back(8'($urandom()));
        pend.push_back(8'($urandom()));
        burst();
        repeat (10) step();
        rst_n = 1'b0;
        #1;
        chk("tx_async_reset", {31'b0, tx}, 32'h1);
        exp_q.delete();
        ovf_m = 1'b0;
        check_status();
        step();
        rst_n = 1'b1;
        repeat (100) begin
            step();
            check_status();
        end

        repeat (4) begin
            int n = $urandom_range(1, 6);
            repeat (n) pend.push_back(8'($urandom()));
            burst();
            run_idle();
            reg_write(32'h0000_1004, 32'h0000_0004);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
